pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 21 ++
 rtl/stack_depth_ctr.sv | 58 +++++
 rtl/pc_sequencer.sv | 119 +++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// ============================================================================
// Module   : pc_sequencer_pkg
// Purpose  : Shared state encoding and register codes for the PC sequencer.
// Revision : 1.0
// ============================================================================
`default_nettype none

package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_RET_WAIT = 2'd1,
        ST_FAULT    = 2'd2
    } seq_state_e;

    localparam logic [4:0] LINK_REG_CODE = 5'b11110;
    localparam logic [4:0] IDLE_REG_CODE = 5'b00000;

endpackage

`default_nettype wire

// File: rtl/stack_depth_ctr.sv
// ============================================================================
// Module   : stack_depth_ctr
// Purpose  : Saturating return-stack depth counter with sticky over/underflow.
// Revision : 1.0
// ============================================================================
`default_nettype none

module stack_depth_ctr #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dec,
    output logic [2:0] depth,
    output logic       overflow,
    output logic       underflow
);

    localparam logic [2:0] MAX_DEPTH = 3'(DEPTH);

    logic [2:0] depth_q, depth_d;
    logic       overflow_q, overflow_d;
    logic       underflow_q, underflow_d;

    always_comb begin
        depth_d     = depth_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        if (inc) begin
            // A call into a full stack evicts the oldest entry, so depth holds.
            if (depth_q == MAX_DEPTH) overflow_d = 1'b1;
            else                      depth_d    = depth_q + 3'd1;
        end else if (dec) begin
            if (depth_q == 3'd0) underflow_d = 1'b1;
            else                 depth_d     = depth_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            depth_q     <= 3'd0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            depth_q     <= depth_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign depth     = depth_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module   : pc_sequencer
// Purpose  : Program-counter sequencer with call/return stack control.
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter logic [4:0]  LINK_REG = LINK_REG_CODE
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        Stall,
    input  logic        BranchValid,
    input  logic [31:0] BranchTarget,
    input  logic        CallValid,
    input  logic [31:0] CallTarget,
    input  logic        RetValid,
    input  logic [31:0] RetAddr,
    output logic [31:0] PC,
    output logic [4:0]  Push,
    output logic [4:0]  Pop,
    output logic [31:0] StackData,
    output logic [2:0]  Depth,
    output logic        Overflow,
    output logic        Underflow,
    output logic        Busy
);

    seq_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [4:0]  push_q, push_d;
    logic [4:0]  pop_q, pop_d;
    logic [31:0] stack_data_q, stack_data_d;
    logic        ctr_inc, ctr_dec;
    logic [2:0]  depth;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        push_d       = IDLE_REG_CODE;
        pop_d        = IDLE_REG_CODE;
        stack_data_d = 32'h0;
        ctr_inc      = 1'b0;
        ctr_dec      = 1'b0;
        if (!Stall) begin
            case (state_q)
                ST_RUN: begin
                    // Return outranks call; a simultaneous call is dropped.
                    if (RetValid) begin
                        ctr_dec = 1'b1;
                        if (depth == 3'd0) begin
                            state_d = ST_FAULT;
                        end else begin
                            pop_d   = LINK_REG;
                            state_d = ST_RET_WAIT;
                        end
                    end else if (CallValid) begin
                        push_d       = LINK_REG;
                        stack_data_d = pc_q;
                        pc_d         = CallTarget;
                        ctr_inc      = 1'b1;
                    end else if (BranchValid) begin
                        pc_d = BranchTarget;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                ST_RET_WAIT: begin
                    pc_d    = RetAddr;
                    state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_RUN;
            pc_q         <= RESET_PC;
            push_q       <= IDLE_REG_CODE;
            pop_q        <= IDLE_REG_CODE;
            stack_data_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            push_q       <= push_d;
            pop_q        <= pop_d;
            stack_data_q <= stack_data_d;
        end
    end

    stack_depth_ctr #(
        .DEPTH (DEPTH)
    ) u_depth_ctr (
        .clk       (CLK),
        .rst       (RST),
        .inc       (ctr_inc),
        .dec       (ctr_dec),
        .depth     (depth),
        .overflow  (Overflow),
        .underflow (Underflow)
    );

    assign PC        = pc_q;
    assign Push      = push_q;
    assign Pop       = pop_q;
    assign StackData = stack_data_q;
    assign Depth     = depth;
    assign Busy      = (state_q == ST_RET_WAIT) || (state_q == ST_FAULT);

endmodule

`default_nettype wire
